// File: rtl/mult_unit_pkg.sv
// rtl/mult_unit_pkg.sv - shared function codes and multiplier state encodings
package mult_unit_pkg;

  // Function-field codes, shared with the main controller decode
  localparam logic [5:0] FUNC_MFHI = 6'h10;
  localparam logic [5:0] FUNC_MFLO = 6'h12;
  localparam logic [5:0] FUNC_MULT = 6'h18;

  // Multiplier sequencer states
  typedef logic [1:0] mstate_t;
  localparam mstate_t MS_IDLE = 2'b00;
  localparam mstate_t MS_CALC = 2'b01;
  localparam mstate_t MS_SIGN = 2'b10;

  // Iteration counter width; kept at least one bit for degenerate widths
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/mult_unit.sv
// rtl/mult_unit.sv - multi-cycle signed shift-add multiplier feeding HI/LO
module mult_unit
  import mult_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             multLoad,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  input  logic             mfRead,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             stall
);

  localparam int            CW   = cnt_width(WIDTH);
  localparam int            PW   = 2 * WIDTH;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  mstate_t          state_q, state_d;
  logic [WIDTH-1:0] mag_a_q, mag_a_d;
  logic [WIDTH-1:0] mag_b_q, mag_b_d;
  logic             neg_res_q, neg_res_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;

  logic [PW-1:0]    partial;
  logic [PW-1:0]    result;

  // Multiplicand aligned to the bit of the multiplier under test this cycle
  assign partial = {{WIDTH{1'b0}}, mag_a_q} << count_q;
  // Magnitudes are multiplied unsigned; the sign is restored in one step at the end
  assign result  = neg_res_q ? (~acc_q + 1'b1) : acc_q;

  // Sequencer and datapath next-state: capture, accumulate, then sign and commit
  always_comb begin
    state_d   = state_q;
    mag_a_d   = mag_a_q;
    mag_b_d   = mag_b_q;
    neg_res_d = neg_res_q;
    acc_d     = acc_q;
    count_d   = count_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    case (state_q)
      MS_IDLE: begin
        if (multLoad) begin
          // |-2^(WIDTH-1)| still fits as an unsigned WIDTH-bit magnitude
          mag_a_d   = opA[WIDTH-1] ? (~opA + 1'b1) : opA;
          mag_b_d   = opB[WIDTH-1] ? (~opB + 1'b1) : opB;
          neg_res_d = opA[WIDTH-1] ^ opB[WIDTH-1];
          acc_d     = '0;
          count_d   = '0;
          state_d   = MS_CALC;
        end
      end
      MS_CALC: begin
        if (mag_b_q[count_q]) begin
          acc_d = acc_q + partial;
        end
        count_d = count_q + 1'b1;
        if (count_q == LAST) begin
          state_d = MS_SIGN;
        end
      end
      MS_SIGN: begin
        {hi_d, lo_d} = result;
        done_d       = 1'b1;
        state_d      = MS_IDLE;
      end
      default: begin
        state_d = MS_IDLE;
      end
    endcase
  end

  // State registers; reset aborts any multiply in flight and clears HI/LO
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= MS_IDLE;
      mag_a_q   <= '0;
      mag_b_q   <= '0;
      neg_res_q <= 1'b0;
      acc_q     <= '0;
      count_q   <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mag_a_q   <= mag_a_d;
      mag_b_q   <= mag_b_d;
      neg_res_q <= neg_res_d;
      acc_q     <= acc_d;
      count_q   <= count_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

  assign hi    = hi_q;
  assign lo    = lo_q;
  assign done  = done_q;
  assign busy  = (state_q != MS_IDLE);
  // Drops in the done cycle, so a held MFHI/MFLO reads the freshly written HI/LO
  assign stall = busy & mfRead;

endmodule
